param_mini_cpu: RTL and testbench

Parametrised successor to the 8-bit two-register mini CPU. It executes one instruction word at a time against a register file of NREGS registers, each WIDTH bits wide. The instruction set adds immediate-add, compare and a multi-cycle shift-add multiply. Instructions enter through a valid/ready handshake; every result is registered. The block sits between the instruction source (switch bank or sequencer) and the display/result logic.

---
 rtl/param_mini_cpu.sv | 200 ++++++++++++++++++++
 tb/tb_param_mini_cpu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mini_cpu.sv
// param_mini_cpu: parametrised register-file CPU executing one instruction at a time.
//
// Instruction word: {op[3:0], rd[RA-1:0], rs[RA-1:0], imm[WIDTH-1:0]}.
// Ports:
//   clk_i               clock, rising edge
//   rst_i               asynchronous active-high clear
//   in_i                instruction word, sampled at the accept edge
//   in_valid_i          in_i holds a valid instruction
//   in_ready_o          block is idle and can accept an instruction
//   out_o               registered result of the last completed instruction
//   overflow_o          overflow of the last completed instruction
//   overflow_sticky_o   OR of overflow results since reset or the last CLR
//   done_o              one-cycle pulse after each completion
//   busy_o              inverse of in_ready_o
module param_mini_cpu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    localparam int unsigned RA = $clog2(NREGS),
    localparam int unsigned IW = 4 + 2 * RA + WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IW-1:0]    in_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_o,
    output logic             overflow_o,
    output logic             overflow_sticky_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpLoad = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpShl  = 4'd2;
    localparam logic [3:0] OpShr  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpCmp  = 4'd6;
    localparam logic [3:0] OpMovo = 4'd7;
    localparam logic [3:0] OpAddi = 4'd8;
    localparam logic [3:0] OpMul  = 4'd9;
    localparam logic [3:0] OpClr  = 4'd15;

    typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

    state_e               state_q;
    logic [3:0]           op_q;
    logic [RA-1:0]        rd_q;
    logic [WIDTH-1:0]     imm_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     regs_q [NREGS];
    logic [WIDTH-1:0]     out_q;
    logic                 ovf_q;
    logic                 sticky_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;

    logic [3:0]           in_op;
    logic [RA-1:0]        in_rd;
    logic [RA-1:0]        in_rs;
    logic [WIDTH-1:0]     in_imm;

    assign in_op  = in_i[IW-1 -: 4];
    assign in_rd  = in_i[IW-5 -: RA];
    assign in_rs  = in_i[IW-5-RA -: RA];
    assign in_imm = in_i[WIDTH-1:0];

    // Single-cycle result path.
    logic [WIDTH:0]   add_rs;
    logic [WIDTH:0]   add_imm;
    logic [WIDTH-1:0] ex_res;
    logic             ex_ovf;
    logic             ex_wr;   // register write-back
    logic             ex_upd;  // out/overflow update (false for NOP)

    always_comb begin
        add_rs  = {1'b0, a_q} + {1'b0, b_q};
        add_imm = {1'b0, a_q} + {1'b0, imm_q};
        ex_res  = '0;
        ex_ovf  = 1'b0;
        ex_wr   = 1'b1;
        ex_upd  = 1'b1;
        case (op_q)
            OpLoad: ex_res = imm_q;
            OpAdd:  {ex_ovf, ex_res} = add_rs;
            OpShl:  begin
                ex_res = {b_q[WIDTH-2:0], 1'b0};
                ex_ovf = b_q[WIDTH-1];
            end
            OpShr:  ex_res = {1'b0, b_q[WIDTH-1:1]};
            OpAnd:  ex_res = a_q & b_q;
            OpOr:   ex_res = a_q | b_q;
            OpCmp:  begin
                ex_wr  = 1'b0;
                ex_res = (a_q > b_q) ? WIDTH'(1) : ((a_q == b_q) ? WIDTH'(2) : WIDTH'(4));
            end
            OpMovo: ex_res = out_q;
            OpAddi: {ex_ovf, ex_res} = add_imm;
            default: begin
                ex_wr  = 1'b0;
                ex_upd = 1'b0;
            end
        endcase
    end

    // Shift-add step: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the upper half when the current LSB is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        imm_q <= in_imm;
                        a_q   <= regs_q[in_rd];
                        b_q   <= regs_q[in_rs];
                        if (in_op == OpMul) begin
                            state_q <= StMul;
                            cnt_q   <= CW'(WIDTH);
                            acc_q   <= {{WIDTH{1'b0}}, regs_q[in_rs]};
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                    if (op_q == OpClr) begin
                        out_q    <= '0;
                        ovf_q    <= 1'b0;
                        sticky_q <= 1'b0;
                        for (int i = 0; i < int'(NREGS); i++) begin
                            regs_q[i] <= '0;
                        end
                    end else if (ex_upd) begin
                        if (ex_wr) begin
                            regs_q[rd_q] <= ex_res;
                        end
                        out_q    <= ex_res;
                        ovf_q    <= ex_ovf;
                        sticky_q <= sticky_q | ex_ovf;
                    end
                end
                StMul: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q      <= StIdle;
                        done_q       <= 1'b1;
                        regs_q[rd_q] <= mul_next[WIDTH-1:0];
                        out_q        <= mul_next[WIDTH-1:0];
                        ovf_q        <= |mul_next[2*WIDTH-1:WIDTH];
                        sticky_q     <= sticky_q | (|mul_next[2*WIDTH-1:WIDTH]);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o        = (state_q == StIdle);
    assign busy_o            = ~in_ready_o;
    assign out_o             = out_q;
    assign overflow_o        = ovf_q;
    assign overflow_sticky_o = sticky_q;
    assign done_o            = done_q;

endmodule

// File: tb/tb_param_mini_cpu.sv
// Randomised self-checking bench for param_mini_cpu (WIDTH=8, NREGS=4) against an
// arithmetic reference model of the instruction set.
module tb_param_mini_cpu;

    localparam int W = 8;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_w = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out;
    logic        ovf;
    logic        sticky;
    logic        done;
    logic        busy;

    always #5 clk = ~clk;

    param_mini_cpu #(
        .WIDTH(W),
        .NREGS(N)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_i             (in_w),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .out_o            (out),
        .overflow_o       (ovf),
        .overflow_sticky_o(sticky),
        .done_o           (done),
        .busy_o           (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_regs [N];
    int m_out;
    int m_ovf;
    int m_sticky;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        m_out = 0;
        m_ovf = 0;
        m_sticky = 0;
    endtask

    // Applies the instruction to the model; returns the expected accept-to-done latency.
    task automatic model_exec(input int op, input int rd, input int rs, input int imm,
                              output int lat);
        int a = m_regs[rd];
        int b = m_regs[rs];
        int w = 0;
        int ov = 0;
        bit wr = 1;
        bit upd = 1;
        case (op)
            0: w = imm;
            1: begin w = (a + b) % 256; ov = int'((a + b) > 255); end
            2: begin w = (b * 2) % 256; ov = int'(b >= 128); end
            3: w = b / 2;
            4: w = a & b;
            5: w = a | b;
            6: begin wr = 0; w = (a > b) ? 1 : ((a == b) ? 2 : 4); end
            7: w = m_out;
            8: begin w = (a + imm) % 256; ov = int'((a + imm) > 255); end
            9: begin w = (a * b) % 256; ov = int'((a * b) > 255); end
            15: begin model_reset(); upd = 0; wr = 0; end
            default: begin upd = 0; wr = 0; end
        endcase
        if (wr) m_regs[rd] = w;
        if (upd) begin
            m_out = w;
            m_ovf = ov;
            m_sticky = m_sticky | ov;
        end
        lat = (op == 9) ? W : 1;
    endtask

    // Presents an instruction from a falling edge and holds it until accepted.
    task automatic send(input int op, input int rd, input int rs, input int imm);
        int guard = 0;
        @(negedge clk);
        in_w = enc(op, rd, rs, imm);
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen; checks outputs against the model.
    task automatic wait_done(input int exp_lat, input string tag);
        int lat = 0;
        while (1) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
            check({tag, "_busy"}, in_ready, 0);
            if (lat > 3 * W) break;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_out"}, out, m_out);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_sticky"}, sticky, m_sticky);
    endtask

    task automatic do_instr(input int op, input int rd, input int rs, input int imm,
                            input string tag);
        int lat;
        model_exec(op, rd, rs, imm, lat);
        send(op, rd, rs, imm);
        wait_done(lat, tag);
    endtask

    // OR Rk,Rk leaves Rk unchanged and exposes it on out.
    task automatic read_reg(input int k, input int exp, input string tag);
        do_instr(5, k, k, 0, tag);
        check({tag, "_val"}, out, exp);
    endtask

    initial begin
        int lat;
        model_reset();

        // Reset state, then release between edges.
        #3;
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        #9 rst = 1'b0;

        // Carry and sticky behaviour.
        do_instr(0, 0, 0, 'hC8, "ld_r0");
        do_instr(0, 1, 0, 'h64, "ld_r1");
        do_instr(1, 0, 1, 0, "add");
        check("add_out_k", out, 'h2C);
        check("add_ovf_k", ovf, 1);
        check("add_sticky_k", sticky, 1);
        do_instr(4, 0, 1, 0, "and");
        check("and_out_k", out, 'h24);
        check("and_ovf_k", ovf, 0);
        check("and_sticky_k", sticky, 1);
        do_instr(15, 0, 0, 0, "clr");
        check("clr_sticky_k", sticky, 0);
        read_reg(1, 0, "clr_rb_r1");

        // Shifts, compare, move-out.
        do_instr(0, 2, 0, 'h81, "ld_r2");
        do_instr(2, 3, 2, 0, "shl");
        check("shl_out_k", out, 'h02);
        check("shl_ovf_k", ovf, 1);
        do_instr(3, 3, 2, 0, "shr");
        check("shr_out_k", out, 'h40);
        do_instr(6, 2, 3, 0, "cmp");
        check("cmp_out_k", out, 'h01);
        do_instr(7, 0, 0, 0, "movo");
        read_reg(0, 'h01, "movo_rb_r0");

        // Multiply.
        do_instr(0, 0, 0, 'h0F, "ld_m0");
        do_instr(0, 1, 0, 'h11, "ld_m1");
        do_instr(9, 0, 1, 0, "mul1");
        check("mul1_out_k", out, 'hFF);
        check("mul1_ovf_k", ovf, 0);
        do_instr(0, 0, 0, 'h10, "ld_m2");
        do_instr(0, 1, 0, 'h10, "ld_m3");
        do_instr(9, 0, 1, 0, "mul2");
        check("mul2_out_k", out, 'h00);
        check("mul2_ovf_k", ovf, 1);

        // Backpressure: ADDI held valid throughout a MUL.
        do_instr(0, 0, 0, 3, "ld_b0");
        do_instr(0, 1, 0, 5, "ld_b1");
        model_exec(9, 0, 1, 0, lat);
        send(9, 0, 1, 0);
        in_w = enc(8, 1, 0, 5);
        in_valid = 1'b1;
        wait_done(lat, "bp_mul");
        model_exec(8, 1, 0, 5, lat);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        wait_done(lat, "bp_addi");
        read_reg(1, 10, "bp_rb_r1");

        // Asynchronous clear in the middle of a MUL.
        do_instr(0, 2, 0, 'h33, "ld_c2");
        model_exec(9, 2, 2, 0, lat);
        send(9, 2, 2, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_out", out, 0);
        check("mrst_ovf", ovf, 0);
        check("mrst_sticky", sticky, 0);
        check("mrst_done", done, 0);
        check("mrst_ready", in_ready, 1);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("mrst_no_done", done, 0);
        end
        do_instr(0, 3, 0, 'h5A, "mrst_ld");
        for (int k = 0; k < 3; k++) read_reg(k, 0, "mrst_rb");
        read_reg(3, 'h5A, "mrst_rb3");

        // Random instruction stream.
        for (int n = 0; n < 200; n++) begin
            int op = $urandom_range(0, 15);
            if (op == 15 && $urandom_range(0, 7) != 0) op = 1;
            do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
                     "rnd");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        for (int k = 0; k < N; k++) read_reg(k, m_regs[k], "final_rb");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
